// File: rtl/batpu_pkg.sv
// rtl/batpu_pkg.sv - shared MMIO address map, screen geometry and RNG step for batpu
package batpu_pkg;

  localparam int SCREEN_W = 32;
  localparam int SCREEN_H = 32;

  localparam logic [7:0] ADDR_PIX_X        = 8'd240;
  localparam logic [7:0] ADDR_PIX_Y        = 8'd241;
  localparam logic [7:0] ADDR_PIX_SET      = 8'd242;
  localparam logic [7:0] ADDR_PIX_CLR      = 8'd243;
  localparam logic [7:0] ADDR_PIX_READ     = 8'd244;
  localparam logic [7:0] ADDR_SCR_PUSH     = 8'd245;
  localparam logic [7:0] ADDR_SCR_CLR      = 8'd246;
  localparam logic [7:0] ADDR_CHAR_WR      = 8'd247;
  localparam logic [7:0] ADDR_CHAR_PUSH    = 8'd248;
  localparam logic [7:0] ADDR_CHAR_CLR     = 8'd249;
  localparam logic [7:0] ADDR_NUM_SHOW     = 8'd250;
  localparam logic [7:0] ADDR_NUM_HIDE     = 8'd251;
  localparam logic [7:0] ADDR_NUM_SIGNED   = 8'd252;
  localparam logic [7:0] ADDR_NUM_UNSIGNED = 8'd253;
  localparam logic [7:0] ADDR_RNG          = 8'd254;
  localparam logic [7:0] ADDR_CTRL         = 8'd255;

  typedef logic [4:0] char_t;

  // Galois mask for x^8+x^6+x^5+x^4+1 in right-shift form
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {1'b0, s[7:1]} ^ (s[0] ? LFSR_TAPS : 8'h00);
  endfunction

endpackage

// File: rtl/batpu_lfsr8.sv
// rtl/batpu_lfsr8.sv - 8-bit maximal-length Galois LFSR, advances one step per enable
module batpu_lfsr8
  import batpu_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic [7:0] value
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) value <= SEED;
    else if (en) value <= lfsr_step(value);
  end

endmodule

// File: rtl/batpu_mmio.sv
// rtl/batpu_mmio.sv - data-side RAM plus MMIO screen/char/number/RNG/controller slave
// Optional: define BATPU_INPUT_SYNC_EN to pass ctrl_in through a 2-flop synchroniser.
module batpu_mmio
  import batpu_pkg::*;
#(
  parameter int         RAM_DEPTH = 240,
  parameter int         NUM_CHARS = 10,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic                   clk,
  input  logic                   async_rst,
  input  logic                   clk_en,
  input  logic                   mem_req,
  input  logic                   mem_we,
  input  logic [7:0]             address,
  input  logic [7:0]             wdata,
  output logic [7:0]             rdata,
  input  logic [7:0]             ctrl_in,
  input  logic [4:0]             disp_x,
  input  logic [4:0]             disp_y,
  output logic                   disp_pixel,
  output logic [5*NUM_CHARS-1:0] chars_front,
  output logic [7:0]             number,
  output logic                   number_valid,
  output logic                   number_signed
);

  localparam int              PTR_W   = $clog2(NUM_CHARS + 1);
  localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(NUM_CHARS);
  localparam logic [7:0]      RAM_TOP = 8'(RAM_DEPTH);

  logic wr, rd;
  assign wr = clk_en & mem_req & mem_we;
  assign rd = clk_en & mem_req & ~mem_we;

  logic [7:0] ram [RAM_DEPTH];

  logic [4:0] pixel_x, pixel_y;
  logic [SCREEN_H-1:0][SCREEN_W-1:0] back, front;
  char_t [NUM_CHARS-1:0] charback, charfront;
  logic [PTR_W-1:0] char_ptr;

  logic [7:0] rng_value;
  logic [7:0] ctrl_value;

  batpu_lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst   (async_rst),
    .en    (rd && address == ADDR_RNG),
    .value (rng_value)
  );

`ifdef BATPU_INPUT_SYNC_EN
  logic [7:0] ctrl_s1, ctrl_s2;
  // Free-running on clk so button edges are captured even while the CPU is stalled
  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      ctrl_s1 <= '0;
      ctrl_s2 <= '0;
    end else begin
      ctrl_s1 <= ctrl_in;
      ctrl_s2 <= ctrl_s1;
    end
  end
  assign ctrl_value = ctrl_s2;
`else
  assign ctrl_value = ctrl_in;
`endif

  // RAM contents are deliberately left unreset
  always_ff @(posedge clk) begin
    if (wr && address < RAM_TOP) ram[address] <= wdata;
  end

  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      pixel_x       <= '0;
      pixel_y       <= '0;
      back          <= '0;
      front         <= '0;
      charback      <= '0;
      charfront     <= '0;
      char_ptr      <= '0;
      number        <= '0;
      number_valid  <= 1'b0;
      number_signed <= 1'b0;
    end else if (wr) begin
      case (address)
        ADDR_PIX_X:        pixel_x <= wdata[4:0];
        ADDR_PIX_Y:        pixel_y <= wdata[4:0];
        ADDR_PIX_SET:      back[pixel_y][pixel_x] <= 1'b1;
        ADDR_PIX_CLR:      back[pixel_y][pixel_x] <= 1'b0;
        ADDR_SCR_PUSH:     front <= back;
        ADDR_SCR_CLR:      back <= '0;
        ADDR_CHAR_WR: begin
          // Saturating pointer: writes past the last char are dropped
          if (char_ptr != PTR_MAX) begin
            charback[char_ptr] <= wdata[4:0];
            char_ptr           <= char_ptr + 1'b1;
          end
        end
        ADDR_CHAR_PUSH:    charfront <= charback;
        ADDR_CHAR_CLR: begin
          charback <= '0;
          char_ptr <= '0;
        end
        ADDR_NUM_SHOW: begin
          number       <= wdata;
          number_valid <= 1'b1;
        end
        ADDR_NUM_HIDE:     number_valid  <= 1'b0;
        ADDR_NUM_SIGNED:   number_signed <= 1'b1;
        ADDR_NUM_UNSIGNED: number_signed <= 1'b0;
        default: ;
      endcase
    end
  end

  always_comb begin
    rdata = 8'h00;
    if (address < RAM_TOP) begin
      rdata = ram[address];
    end else begin
      case (address)
        ADDR_PIX_READ: rdata = {7'b0, back[pixel_y][pixel_x]};
        ADDR_RNG:      rdata = rng_value;
        ADDR_CTRL:     rdata = ctrl_value;
        default:       rdata = 8'h00;
      endcase
    end
  end

  assign disp_pixel  = front[disp_y][disp_x];
  assign chars_front = charfront;

endmodule

// File: doc/batpu_mmio.md
Name: batpu_mmio

Overview:
- Data-side memory and I/O slave sitting directly downstream of the CPU's data port (mem_req/mem_we/data_address/data_out).
- Provides 240 bytes of general RAM and a 16-byte MMIO window.
- The MMIO window covers a double-buffered 32x32 pixel screen, a 10-char text display, a number display, an LFSR RNG and a controller input port.
- Returns read data to the CPU's data_in in the same cycle as the request.

Parameters:
- RAM_DEPTH, 240, number of RAM bytes at addresses 0..RAM_DEPTH-1; MMIO base fixed at 240.
- NUM_CHARS, 10, character display length.
- LFSR_SEED, 8'hA5, RNG reset value; must be nonzero.

Ports:
- clk  in  1  system clock
- async_rst  in  1  asynchronous active-high reset
- clk_en  in  1  global clock enable; no state changes when low
- mem_req  in  1  CPU data access request
- mem_we  in  1  1=write, 0=read; valid with mem_req
- address  in  8  CPU data_address
- wdata  in  8  CPU data_out
- rdata  out  8  to CPU data_in
- ctrl_in  in  8  controller buttons (raw)
- disp_x  in  5  display scan column
- disp_y  in  5  display scan row
- disp_pixel  out  1  front screen buffer bit at (disp_x, disp_y), combinational
- chars_front  out  5*NUM_CHARS  front char buffer; char 0 in LSBs
- number  out  8  number display value
- number_valid  out  1  number display on
- number_signed  out  1  1=display number as two's complement

Behaviour:
- Clock/reset: one clock, clk. Reset is async_rst, asynchronous and active-high.
- Reset values:
  - rdata follows its combinational rule.
  - All buffers, pixel_x/pixel_y, char_ptr, number, number_valid and number_signed clear to 0.
  - LFSR loads LFSR_SEED.
  - RAM contents are not reset.
- Access qualifiers:
  - wr = clk_en & mem_req & mem_we.
  - rd = clk_en & mem_req & ~mem_we.
  - All state updates occur on the clk rising edge while the qualifier is true.
  - One access per cycle, so no simultaneous-event arbitration is needed.
- Read data, combinational from address, not gated by mem_req:
  - 0..239: RAM[address].
  - 244: {7'b0, back[pixel_y][pixel_x]}.
  - 254: current LFSR value.
  - 255: ctrl_in (synchronised if the optional feature is enabled).
  - All other MMIO addresses: 8'h00.
- Read side effect: rd at 254 advances the LFSR one step after the current value is returned. Polynomial x^8+x^6+x^5+x^4+1, Galois form; the state never reaches 0.
- Write map (wr):
  - 0..239: RAM write.
  - 240: pixel_x <= wdata[4:0].
  - 241: pixel_y <= wdata[4:0].
  - 242: back[pixel_y][pixel_x] <= 1.
  - 243: back[pixel_y][pixel_x] <= 0.
  - 244: ignored.
  - 245: front <= back (whole 1024 bits in one cycle).
  - 246: back <= 0.
  - 247: charback[char_ptr] <= wdata[4:0]; char_ptr++.
  - 248: chars_front <= charback.
  - 249: charback <= 0; char_ptr <= 0.
  - 250: number <= wdata; number_valid <= 1.
  - 251: number_valid <= 0; number is retained.
  - 252: number_signed <= 1.
  - 253: number_signed <= 0.
  - 254, 255: ignored.
- Char boundary: when char_ptr == NUM_CHARS, writes to 247 are dropped and the pointer saturates (no wrap).
- Pixel write to 240/241 followed by 242 in the next cycle uses the new coordinates.
- Reset mid-sequence: buffers and pointers clear immediately; the next access sees reset state.

Optional Feature:
- Macro: BATPU_INPUT_SYNC_EN.
- Defined: ctrl_in passes through a 2-flop synchroniser clocked every clk (not gated by clk_en) and reset to 0. A read at 255 returns the synchronised value, so ctrl_in changes are visible after 2 cycles.
- Undefined: ctrl_in is returned combinationally with zero latency.

Decomposition:
- Shared package batpu_pkg holds:
  - MMIO address localparams (ADDR_PIX_X=240 ... ADDR_CTRL=255).
  - SCREEN_W/SCREEN_H=32.
  - char_t (5-bit) typedef.
- One sub-module, batpu_lfsr8: enable, seed on reset, current-value output.
- Screen and char buffers stay inline.

Test Plan:
- RAM: write 8'h3C to 17, then read 17 -> rdata=8'h3C. Read 241 -> 8'h00. Write with clk_en=0, then read -> old value.
- Screen: write 240<=5, 241<=9, 242, then read 244 -> 8'h01. disp_pixel at (5,9) stays 0 until a write to 245, then 1. Write 246, read 244 -> 0, front still 1.
- Chars: write 249, then 11 writes to 247 with values 1..11, then 248 -> chars_front holds 1..10. The 11th write is dropped.
- Number: write 250<=8'hF6, then 252 -> number=F6, valid=1, signed=1. Write 251 -> valid=0, number still F6.
- RNG: reset, read 254 -> 8'hA5. 255 successive reads are all nonzero and distinct; the 256th read -> 8'hA5. Reads to 253 do not advance the LFSR.
- Async reset asserted mid-cycle after screen/char writes -> all outputs 0 immediately, without waiting for a clk edge. With BATPU_INPUT_SYNC_EN: ctrl_in=8'h81 -> read 255 returns 8'h81 no earlier than 2 clk edges later.
